reset_sequencer: RTL and testbench

RESET_SEQUENCER -- requirements
Module: reset_sequencer

---
 rtl/reset_sequencer_pkg.sv | 27 ++
 rtl/reset_sequencer_lock_filter.sv | 48 ++++
 rtl/reset_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_reset_sequencer.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/reset_sequencer_pkg.sv
// Shared definitions for the reset sequencer: state encoding, default
// parameter values and small elaboration-time helpers.
package reset_sequencer_pkg;

   localparam int DEF_LOCK_FILTER  = 16;
   localparam int DEF_HOLD_CYCLES  = 1024;
   localparam int DEF_INIT_TIMEOUT = 65535;
   localparam int DEF_MAX_RETRIES  = 3;

   typedef enum logic [2:0] {
      ST_WAIT_LOCK = 3'd0,
      ST_HOLD      = 3'd1,
      ST_WAIT_INIT = 3'd2,
      ST_RUN       = 3'd3,
      ST_FAULT     = 3'd4
   } seq_state_e;

   // Bits needed to hold values 0..n-1, never less than one bit.
   function automatic int cnt_width(input int n);
      return (n < 2) ? 1 : $clog2(n);
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/reset_sequencer_lock_filter.sv
// PLL lock qualification: two-flop synchronizer followed by a saturating
// counter of consecutive synchronized-high cycles.
module reset_sequencer_lock_filter
   import reset_sequencer_pkg::*;
#(
   parameter int LOCK_FILTER = DEF_LOCK_FILTER
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_pll_locked,
   output logic o_lock_s,
   output logic o_lock_ok
);

   // Counter must be able to hold LOCK_FILTER itself; it saturates there.
   localparam int CNT_W = cnt_width(LOCK_FILTER + 1);
   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_FILTER);

   logic             r_sync1;
   logic             r_sync2;
   logic [CNT_W-1:0] r_cnt;

   // Bring the asynchronous lock indication into the clk domain.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
      end else begin
         r_sync1 <= i_pll_locked;
         r_sync2 <= r_sync1;
      end
   end

   // Count consecutive high samples; any low sample restarts the count.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!r_sync2) begin
         r_cnt <= '0;
      end else if (r_cnt != CNT_MAX) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_lock_s  = r_sync2;
   assign o_lock_ok = (r_cnt == CNT_MAX);

endmodule

// File: rtl/reset_sequencer.sv
// Power-up reset sequencer: qualifies PLL lock, holds all domains in reset,
// releases core and codec, waits for codec init (with bounded retries),
// then releases the DSP datapath.
//
//   state        | meaning
//   -------------+------------------------------------------------------
//   WAIT_LOCK    | all resets asserted, waiting for filtered PLL lock
//   HOLD         | fixed settle time; codec/dsp in reset, core held low
//                | only on the first attempt
//   WAIT_INIT    | core and codec released, waiting for codec_init_done
//   RUN          | everything released, sequencing complete
//   FAULT        | init retries exhausted; core up, codec/dsp held
module reset_sequencer
   import reset_sequencer_pkg::*;
#(
   parameter int LOCK_FILTER  = DEF_LOCK_FILTER,
   parameter int HOLD_CYCLES  = DEF_HOLD_CYCLES,
   parameter int INIT_TIMEOUT = DEF_INIT_TIMEOUT,
   parameter int MAX_RETRIES  = DEF_MAX_RETRIES
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       pll_locked,
   input  logic       codec_init_done,
   output logic       rst_core_n,
   output logic       rst_codec_n,
   output logic       rst_dsp_n,
   output logic       seq_busy,
   output logic       seq_error,
   output logic [1:0] retry_cnt
);

   // One down-counter serves both HOLD and WAIT_INIT; each phase loads
   // its length minus one and ends on the terminal count of zero.
   localparam int TMR_W = cnt_width(max_int(HOLD_CYCLES, INIT_TIMEOUT));
   localparam logic [TMR_W-1:0] HOLD_LOAD = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] INIT_LOAD = TMR_W'(INIT_TIMEOUT - 1);

   logic             w_lock_s;
   logic             w_lock_ok;

   seq_state_e       r_state;
   seq_state_e       w_state_nxt;
   logic [TMR_W-1:0] r_timer;
   logic [TMR_W-1:0] w_timer_nxt;
   logic [1:0]       r_retry;
   logic [1:0]       w_retry_nxt;

   logic             r_rst_core_n;
   logic             r_rst_codec_n;
   logic             r_rst_dsp_n;
   logic             r_seq_busy;
   logic             r_seq_error;
   logic             w_core_nxt;
   logic             w_codec_nxt;
   logic             w_dsp_nxt;
   logic             w_busy_nxt;
   logic             w_error_nxt;

   reset_sequencer_lock_filter #(
      .LOCK_FILTER (LOCK_FILTER)
   ) u_lock_filter (
      .clk          (clk),
      .rst_n        (rst_n),
      .i_pll_locked (pll_locked),
      .o_lock_s     (w_lock_s),
      .o_lock_ok    (w_lock_ok)
   );

   // Next-state, timer, retry and output decode.
   always_comb begin
      w_state_nxt = r_state;
      w_timer_nxt = r_timer;
      w_retry_nxt = r_retry;
      w_error_nxt = r_seq_error;

      case (r_state)
         ST_WAIT_LOCK: begin
            if (w_lock_ok) begin
               w_state_nxt = ST_HOLD;
               w_timer_nxt = HOLD_LOAD;
            end
         end
         ST_HOLD: begin
            if (!w_lock_s) begin
               w_state_nxt = ST_WAIT_LOCK;
            end else if (r_timer == '0) begin
               w_state_nxt = ST_WAIT_INIT;
               w_timer_nxt = INIT_LOAD;
            end else begin
               w_timer_nxt = r_timer - TMR_W'(1);
            end
         end
         ST_WAIT_INIT: begin
            // Lock loss outranks both completion and timeout.
            if (!w_lock_s) begin
               w_state_nxt = ST_WAIT_LOCK;
            end else if (codec_init_done) begin
               w_state_nxt = ST_RUN;
               w_error_nxt = 1'b0;
            end else if (r_timer == '0) begin
               w_error_nxt = 1'b1;
               if (r_retry != 2'd3) begin
                  w_retry_nxt = r_retry + 2'd1;
               end
               if (int'(r_retry) + 1 >= MAX_RETRIES) begin
                  w_state_nxt = ST_FAULT;
               end else begin
                  w_state_nxt = ST_HOLD;
                  w_timer_nxt = HOLD_LOAD;
               end
            end else begin
               w_timer_nxt = r_timer - TMR_W'(1);
            end
         end
         ST_RUN, ST_FAULT: begin
            if (!w_lock_s) begin
               w_state_nxt = ST_WAIT_LOCK;
            end
         end
         default: begin
            w_state_nxt = ST_WAIT_LOCK;
         end
      endcase

      if (w_state_nxt == ST_WAIT_LOCK) begin
         w_timer_nxt = '0;
         w_retry_nxt = '0;
         w_error_nxt = 1'b0;
      end

      w_core_nxt  = 1'b0;
      w_codec_nxt = 1'b0;
      w_dsp_nxt   = 1'b0;
      w_busy_nxt  = 1'b1;
      case (w_state_nxt)
         ST_HOLD: begin
            // A retry re-holds only the codec; the core stays released.
            w_core_nxt = (w_retry_nxt != 2'd0);
         end
         ST_WAIT_INIT: begin
            w_core_nxt  = 1'b1;
            w_codec_nxt = 1'b1;
         end
         ST_RUN: begin
            w_core_nxt  = 1'b1;
            w_codec_nxt = 1'b1;
            w_dsp_nxt   = 1'b1;
            w_busy_nxt  = 1'b0;
         end
         ST_FAULT: begin
            w_core_nxt = 1'b1;
            w_busy_nxt = 1'b0;
         end
         default: begin
            w_core_nxt = 1'b0;
         end
      endcase
   end

   // State, counters and registered outputs.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state       <= ST_WAIT_LOCK;
         r_timer       <= '0;
         r_retry       <= '0;
         r_rst_core_n  <= 1'b0;
         r_rst_codec_n <= 1'b0;
         r_rst_dsp_n   <= 1'b0;
         r_seq_busy    <= 1'b1;
         r_seq_error   <= 1'b0;
      end else begin
         r_state       <= w_state_nxt;
         r_timer       <= w_timer_nxt;
         r_retry       <= w_retry_nxt;
         r_rst_core_n  <= w_core_nxt;
         r_rst_codec_n <= w_codec_nxt;
         r_rst_dsp_n   <= w_dsp_nxt;
         r_seq_busy    <= w_busy_nxt;
         r_seq_error   <= w_error_nxt;
      end
   end

   assign rst_core_n  = r_rst_core_n;
   assign rst_codec_n = r_rst_codec_n;
   assign rst_dsp_n   = r_rst_dsp_n;
   assign seq_busy    = r_seq_busy;
   assign seq_error   = r_seq_error;
   assign retry_cnt   = r_retry;

endmodule

// File: tb/tb_reset_sequencer.sv
// Bench for reset_sequencer: directed scenarios plus randomized lock/done
// activity, compared every cycle against a timeline model.
module tb_reset_sequencer;

   localparam int LF = 4;
   localparam int HC = 8;
   localparam int IT = 20;
   localparam int MR = 2;
   localparam int T_REL = 2 + LF + HC;

   // {core, codec, dsp, busy, error, retry[1:0]}
   localparam logic [6:0] RST_OUTS = 7'b000_1_0_00;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       pll_locked;
   logic       codec_init_done;
   logic       rst_core_n;
   logic       rst_codec_n;
   logic       rst_dsp_n;
   logic       seq_busy;
   logic       seq_error;
   logic [1:0] retry_cnt;
   logic [6:0] w_outs;

   int n_chk = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   reset_sequencer #(
      .LOCK_FILTER  (LF),
      .HOLD_CYCLES  (HC),
      .INIT_TIMEOUT (IT),
      .MAX_RETRIES  (MR)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .pll_locked      (pll_locked),
      .codec_init_done (codec_init_done),
      .rst_core_n      (rst_core_n),
      .rst_codec_n     (rst_codec_n),
      .rst_dsp_n       (rst_dsp_n),
      .seq_busy        (seq_busy),
      .seq_error       (seq_error),
      .retry_cnt       (retry_cnt)
   );

   assign w_outs = {rst_core_n, rst_codec_n, rst_dsp_n, seq_busy, seq_error, retry_cnt};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s at %0t: got 0x%0h expected 0x%0h", tag, $time, obs, exp);
      end
   endtask

   // Timeline model: sequencing is "active" from the edge lock is
   // qualified; the phase is derived from elapsed edges since m_start.
   bit m_hist[$];   // pll samples since reset, one per edge
   int m_e;         // index of the latest edge since reset release
   int m_run;       // consecutive synchronized-high samples so far
   bit m_active;
   bit m_running;
   bit m_fault;
   int m_start;     // edge at which the current hold period began
   int m_retry;

   task automatic m_clear();
      m_hist.delete();
      m_e       = -1;
      m_run     = 0;
      m_active  = 0;
      m_running = 0;
      m_fault   = 0;
      m_start   = 0;
      m_retry   = 0;
   endtask

   task automatic m_step(input bit p, input bit d);
      bit ls;
      int el;
      m_e++;
      // Synchronized lock seen at this edge is the sample two edges back.
      ls = (m_hist.size() >= 2) ? m_hist[m_hist.size() - 2] : 1'b0;
      if (m_active) begin
         if (!ls) begin
            m_active  = 0;
            m_running = 0;
            m_fault   = 0;
            m_retry   = 0;
         end else if (!m_running && !m_fault) begin
            el = m_e - m_start;
            if (el > HC && d) begin
               m_running = 1;
            end else if (el == HC + IT) begin
               m_retry++;
               if (m_retry >= MR) m_fault = 1;
               else m_start = m_e;
            end
         end
      end else if (m_run >= LF) begin
         m_active = 1;
         m_start  = m_e;
      end
      m_run = ls ? m_run + 1 : 0;
      m_hist.push_back(p);
   endtask

   function automatic logic [6:0] m_expect();
      int el;
      logic rb;
      rb = (m_retry > 0);
      if (!m_active)  return RST_OUTS;
      if (m_fault)    return {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'(m_retry)};
      if (m_running)  return {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 2'(m_retry)};
      el = m_e - m_start;
      if (el < HC)    return {rb, 1'b0, 1'b0, 1'b1, rb, 2'(m_retry)};
      return {1'b1, 1'b1, 1'b0, 1'b1, rb, 2'(m_retry)};
   endfunction

   // One clock: drive inputs for the coming edge, step the model, compare.
   task automatic cyc(input bit p, input bit d);
      pll_locked      = p;
      codec_init_done = d;
      @(posedge clk);
      m_step(p, d);
      #1 check("outs", 32'(w_outs), 32'(m_expect()));
   endtask

   // Mid-cycle asynchronous reset; outputs must drop before any edge.
   task automatic apply_reset();
      #2 rst_n = 1'b0;
      #1 check("rst_async", 32'(w_outs), 32'(RST_OUTS));
      m_clear();
      pll_locked      = 1'b0;
      codec_init_done = 1'b0;
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic run_random(input int n);
      bit p;
      bit d;
      int low_left;
      low_left = 0;
      for (int i = 0; i < n; i++) begin
         if (low_left > 0) begin
            p = 1'b0;
            low_left--;
         end else if ($urandom_range(149) == 0) begin
            p = 1'b0;
            low_left = int'($urandom_range(4, 0));
         end else begin
            p = 1'b1;
         end
         d = ($urandom_range(39) == 0);
         cyc(p, d);
         if ($urandom_range(599) == 0) apply_reset();
      end
   endtask

   initial begin
      rst_n           = 1'b1;
      pll_locked      = 1'b0;
      codec_init_done = 1'b0;
      m_clear();
      #1 rst_n = 1'b0;
      #1 check("reset_init", 32'(w_outs), 32'(RST_OUTS));
      @(posedge clk);
      @(posedge clk);
      #1 rst_n = 1'b1;

      // Clean lock from edge 0, done sampled at edge 21.
      for (int i = 0; i < 30; i++) begin
         cyc(1'b1, (m_e + 1) >= 21);
         if (m_e == T_REL - 1) check("core_early", 32'(rst_core_n), 0);
         if (m_e == T_REL) begin
            check("core_rise", 32'(rst_core_n), 1);
            check("codec_rise", 32'(rst_codec_n), 1);
         end
         if (m_e == 20) check("dsp_early", 32'(rst_dsp_n), 0);
         if (m_e == 21) begin
            check("dsp_rise", 32'(rst_dsp_n), 1);
            check("busy_fall", 32'(seq_busy), 0);
         end
      end

      // Lock lost in RUN for one sample at edge 30; done held high
      // throughout so it must be ignored until WAIT_INIT.
      cyc(1'b0, 1'b1);
      for (int i = 0; i < 25; i++) begin
         cyc(1'b1, 1'b1);
         if (m_e == 31) check("core_still_up", 32'(rst_core_n), 1);
         if (m_e == 32) begin
            check("resets_low", 32'(w_outs[6:4]), 0);
            check("retry_clr", 32'(retry_cnt), 0);
         end
         if (m_e == 45) check("dsp_wait", 32'(rst_dsp_n), 0);
         if (m_e == 46) check("dsp_reseq", 32'(rst_dsp_n), 1);
      end

      // One-sample lock glitch at edge 3 restarts the filter.
      apply_reset();
      for (int i = 0; i < 24; i++) begin
         cyc((m_e + 1) != 3, 1'b0);
         if (m_e == T_REL + 3) check("glitch_core_early", 32'(rst_core_n), 0);
         if (m_e == T_REL + 4) check("glitch_core_rise", 32'(rst_core_n), 1);
      end

      // Done never arrives: two timeouts then FAULT.
      apply_reset();
      for (int i = 0; i < 80; i++) begin
         cyc(1'b1, 1'b0);
         if (m_e == T_REL + IT) begin
            check("retry1", 32'(retry_cnt), 1);
            check("retry1_codec", 32'(rst_codec_n), 0);
            check("retry1_core", 32'(rst_core_n), 1);
            check("retry1_err", 32'(seq_error), 1);
         end
      end
      check("fault_retry", 32'(retry_cnt), 2);
      check("fault_err", 32'(seq_error), 1);
      check("fault_codec", 32'(rst_codec_n), 0);
      check("fault_core", 32'(rst_core_n), 1);
      check("fault_busy", 32'(seq_busy), 0);

      // Reset pulse in the middle of HOLD.
      apply_reset();
      for (int i = 0; i < 10; i++) cyc(1'b1, 1'b0);
      check("in_hold_busy", 32'(seq_busy), 1);
      apply_reset();

      // Lock loss and done in the same cycle: loss wins.
      for (int i = 0; i < 24; i++) begin
         cyc((m_e + 1) != 18, (m_e + 1) == 20);
         if (m_e == 20) begin
            check("prio_dsp", 32'(rst_dsp_n), 0);
            check("prio_core", 32'(rst_core_n), 0);
         end
         if (m_e == 21) check("prio_dsp_next", 32'(rst_dsp_n), 0);
      end

      apply_reset();
      run_random(5000);

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
